// File: rtl/bitty_pkg.sv
// -----------------------------------------------------------------------------
// bitty_pkg
// Shared definitions for the Bitty instruction-fetch slice.
//   INSTR_W         : width of one instruction word
//   DEFAULT_DEPTH   : default program memory depth (words, power of two)
//   DEFAULT_TIMEOUT : default watchdog limit in cycles spent waiting for done
//   fetch_state_t   : sequencer state encoding
// -----------------------------------------------------------------------------
package bitty_pkg;

   localparam int INSTR_W         = 16;
   localparam int DEFAULT_DEPTH   = 256;
   localparam int DEFAULT_TIMEOUT = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      WAIT  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/bitty_imem.sv
// -----------------------------------------------------------------------------
// bitty_imem
// Single-port program RAM, DEPTH x INSTR_W, with a registered read port.
// Ports:
//   clk, reset : clock and asynchronous active-low reset (read register only)
//   we         : write wdata at addr on the rising edge
//   re         : capture mem[addr] into rdata on the rising edge
//   addr       : shared write/read address
//   wdata      : write data
//   rdata      : registered read data, holds its value while re is low
// -----------------------------------------------------------------------------
module bitty_imem
   import bitty_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic               re,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [INSTR_W-1:0] wdata,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem [DEPTH];

   // Storage is deliberately not reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // The read register is reset so the instruction bus comes up as zero,
   // and it only updates on a fetch so the word stays stable while waiting.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/bitty_fetch_unit.sv
// -----------------------------------------------------------------------------
// bitty_fetch_unit
// Instruction sequencer for the Bitty core. Fetches words from program memory,
// issues each one with a single-cycle run pulse and waits for the core's done
// before advancing. A watchdog aborts the program if done never arrives.
// Handshake: the unit is the initiator. run is high for exactly one cycle with
// instraction valid; instraction then stays stable until the core answers with
// done (sampled only while waiting). done at any other time is ignored.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   load_en/load_addr/load_data : program memory write port (IDLE only)
//   prog_len    : instruction count, sampled on start (clamped to DEPTH)
//   start       : begin execution from address 0 (IDLE only)
//   done        : core has finished the current instruction
//   instraction : instruction word to the core
//   run         : one-cycle issue pulse
//   pc          : address of the current instruction
//   busy        : sequencer is not IDLE
//   halted      : sticky, last instruction completed
//   error       : sticky, watchdog expired
//   state_dbg   : current sequencer state
// -----------------------------------------------------------------------------
module bitty_fetch_unit
   import bitty_pkg::*;
#(
   parameter int DEPTH   = DEFAULT_DEPTH,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_en,
   input  logic [ADDR_W-1:0]  load_addr,
   input  logic [INSTR_W-1:0] load_data,
   input  logic [ADDR_W:0]    prog_len,
   input  logic               start,
   input  logic               done,
   output logic [INSTR_W-1:0] instraction,
   output logic               run,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               halted,
   output logic               error,
   output fetch_state_t       state_dbg
);

   localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   fetch_state_t        state_q;
   logic [ADDR_W-1:0]   pc_q;
   logic [ADDR_W:0]     len_q;
   logic [WD_W-1:0]     wd_q;
   logic                halted_q;
   logic                error_q;

   logic [ADDR_W:0]     len_in;
   logic                is_last;
   logic                mem_we;
   logic                mem_re;
   logic [ADDR_W-1:0]   mem_addr;
   logic [INSTR_W-1:0]  mem_rdata;

   // Clamping the length keeps pc inside the memory, so pc never wraps.
   assign len_in  = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
   // len_q is non-zero whenever this is consulted (zero length never leaves IDLE).
   assign is_last = ({1'b0, pc_q} == (len_q - 1'b1));

   // Load owns the address in IDLE, fetch owns it elsewhere.
   assign mem_we   = (state_q == IDLE) && load_en;
   assign mem_re   = (state_q == FETCH);
   assign mem_addr = (state_q == IDLE) ? load_addr : pc_q;

   bitty_imem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_imem (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (mem_addr),
      .wdata (load_data),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         len_q    <= '0;
         wd_q     <= '0;
         halted_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  len_q    <= len_in;
                  pc_q     <= '0;
                  error_q  <= 1'b0;
                  halted_q <= (len_in == '0);
                  state_q  <= (len_in == '0) ? IDLE : FETCH;
               end
            end
            FETCH: begin
               state_q <= ISSUE;
            end
            ISSUE: begin
               wd_q    <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               // done wins over a watchdog expiry in the same cycle.
               if (done) begin
                  if (is_last) begin
                     halted_q <= 1'b1;
                     state_q  <= IDLE;
                  end else begin
                     pc_q    <= pc_q + 1'b1;
                     state_q <= FETCH;
                  end
               end else if (wd_q == WD_LAST) begin
                  error_q <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // The read register captured the word during FETCH, so it is valid in the
   // ISSUE cycle and unchanged until the next FETCH.
   assign instraction = mem_rdata;
   assign run         = (state_q == ISSUE);
   assign pc          = pc_q;
   assign busy        = (state_q != IDLE);
   assign halted      = halted_q;
   assign error       = error_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_bitty_fetch_unit
// Bench for bitty_fetch_unit with a small memory and short watchdog.
// -----------------------------------------------------------------------------
module tb_bitty_fetch_unit;
   import bitty_pkg::*;

   localparam int DEPTH   = 16;
   localparam int ADDR_W  = 4;
   localparam int TIMEOUT = 16;

   // ---------------- clock / reset / signals ----------------
   logic               clk       = 1'b0;
   logic               reset     = 1'b0;
   logic               load_en   = 1'b0;
   logic [ADDR_W-1:0]  load_addr = '0;
   logic [15:0]        load_data = '0;
   logic [ADDR_W:0]    prog_len  = '0;
   logic               start     = 1'b0;
   logic               done      = 1'b0;
   logic [15:0]        instraction;
   logic               run;
   logic [ADDR_W-1:0]  pc;
   logic               busy;
   logic               halted;
   logic               error;
   fetch_state_t       state_dbg;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // reference model state
   logic [15:0] mem_m [DEPTH];
   logic [15:0] exp_q [$];
   int          runs          = 0;
   int          start_cyc     = 0;
   int          last_done_cyc = 0;
   int          first_pending = 0;
   int          resp_delay    = 4;   // 0 selects a random delay per instruction
   int          cd_m          = 0;
   bit          resp_en       = 1'b1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bitty_fetch_unit #(
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .prog_len    (prog_len),
      .start       (start),
      .done        (done),
      .instraction (instraction),
      .run         (run),
      .pc          (pc),
      .busy        (busy),
      .halted      (halted),
      .error       (error),
      .state_dbg   (state_dbg)
   );

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- core model + issue monitor ----------------
   initial begin : core_model
      forever begin
         @(negedge clk);
         if (resp_en) begin
            if (cd_m > 0) begin
               cd_m--;
               if (cd_m == 0) begin
                  done = 1'b1;
                  last_done_cyc = cyc;
               end
            end else begin
               done = 1'b0;
            end
         end
         if (run === 1'b1) begin
            runs++;
            check("run_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("instraction", 32'(instraction), 32'(exp_q.pop_front()));
            if (first_pending != 0) begin
               check("first_issue_lat", cyc - start_cyc, 2);
               first_pending = 0;
            end else if (resp_en) begin
               check("issue_lat", cyc - last_done_cyc, 2);
            end
            if (resp_en) cd_m = (resp_delay > 0) ? resp_delay : $urandom_range(1, 10);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_word(input int a, input logic [15:0] d);
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = a[ADDR_W-1:0];
      load_data = d;
      mem_m[a]  = d;
      @(negedge clk);
      load_en   = 1'b0;
   endtask

   task automatic start_prog(input int n, input bit do_load, input int a, input logic [15:0] d);
      int e;
      e = (n > DEPTH) ? DEPTH : n;
      @(negedge clk);
      if (do_load) begin
         load_en   = 1'b1;
         load_addr = a[ADDR_W-1:0];
         load_data = d;
         mem_m[a]  = d;
      end
      prog_len      = n[ADDR_W:0];
      start         = 1'b1;
      start_cyc     = cyc;
      first_pending = 1;
      runs          = 0;
      for (int i = 0; i < e; i++) exp_q.push_back(mem_m[i]);
      @(negedge clk);
      start   = 1'b0;
      load_en = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy; i++) @(negedge clk);
      check("idle_in_time", busy, 0);
   endtask

   task automatic wait_run(input int budget);
      for (int i = 0; i < budget && !run; i++) @(negedge clk);
      check("run_in_time", run, 1);
   endtask

   task automatic finish_prog(input int n);
      int e;
      e = (n > DEPTH) ? DEPTH : n;
      wait_idle(400);
      check("halted_end", halted, 1);
      check("error_end", error, 0);
      check("pc_end", 32'(pc), (e == 0) ? 0 : e - 1);
      check("run_count", runs, e);
      check("exp_q_empty", exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   int r;
   int n;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_instraction", 32'(instraction), 0);
      check("rst_run", run, 0);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_error", error, 0);
      check("rst_pc", 32'(pc), 0);
      check("rst_state", 32'(state_dbg), 32'(IDLE));
      reset = 1'b1;

      for (int i = 0; i < DEPTH; i++) load_word(i, 16'($urandom()));

      // three-word program, fixed core latency of 4
      load_word(0, 16'h1111);
      load_word(1, 16'h2222);
      load_word(2, 16'h3333);
      resp_en = 1'b1; resp_delay = 4;
      start_prog(3, 0, 0, 16'h0);
      finish_prog(3);

      // watchdog: core never answers
      resp_en = 1'b0; done = 1'b0;
      start_prog(3, 0, 0, 16'h0);
      wait_run(20);
      r = cyc;
      for (int i = 0; i < 40 && !error; i++) @(negedge clk);
      check("to_error", error, 1);
      check("to_latency", cyc - r, TIMEOUT + 1);
      check("to_pc", 32'(pc), 0);
      check("to_busy", busy, 0);
      check("to_halted", halted, 0);
      check("to_runs", runs, 1);
      check("to_unissued", exp_q.size(), 2);
      exp_q.delete();

      // zero-length program clears error and halts at once
      start_prog(0, 0, 0, 16'h0);
      check("zero_halted", halted, 1);
      check("zero_busy", busy, 0);
      check("zero_error", error, 0);
      repeat (4) @(negedge clk);
      finish_prog(0);

      // loads and starts while running are ignored
      resp_en = 1'b1; resp_delay = 6;
      start_prog(3, 0, 0, 16'h0);
      repeat (2) @(negedge clk);
      load_en = 1'b1; load_addr = 4'd1; load_data = 16'hDEAD;
      prog_len = 5'd1; start = 1'b1;
      @(negedge clk);
      load_en = 1'b0; start = 1'b0;
      finish_prog(3);
      start_prog(3, 0, 0, 16'h0);
      finish_prog(3);

      // done in the ISSUE cycle is ignored, done in WAIT advances
      resp_en = 1'b0; done = 1'b0;
      start_prog(2, 0, 0, 16'h0);
      wait_run(20);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("issue_done_pc", 32'(pc), 0);
      check("issue_done_state", 32'(state_dbg), 32'(WAIT));
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("wait_done_pc", 32'(pc), 1);
      check("wait_done_state", 32'(state_dbg), 32'(FETCH));
      wait_run(20);
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      finish_prog(2);

      // reset while waiting
      start_prog(3, 0, 0, 16'h0);
      wait_run(20);
      @(negedge clk);
      check("pre_rst_state", 32'(state_dbg), 32'(WAIT));
      r = runs;
      reset = 1'b0;
      #1;
      check("mid_rst_instraction", 32'(instraction), 0);
      check("mid_rst_run", run, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_halted", halted, 0);
      check("mid_rst_error", error, 0);
      check("mid_rst_pc", 32'(pc), 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("no_run_after_rst", runs, r);
      exp_q.delete();
      resp_en = 1'b1; resp_delay = 3;
      start_prog(1, 0, 0, 16'h0);
      finish_prog(1);

      // write and start in the same cycle
      start_prog(2, 1, 0, 16'hA5C3);
      finish_prog(2);

      // randomized programs, including clamped lengths
      resp_delay = 0;
      for (int it = 0; it < 8; it++) begin
         for (int k = 0; k < int'($urandom_range(0, 3)); k++)
            load_word($urandom_range(0, DEPTH - 1), 16'($urandom()));
         n = (it == 0) ? 20 : (it == 1) ? DEPTH : $urandom_range(0, 2 * DEPTH - 1);
         start_prog(n, 0, 0, 16'h0);
         finish_prog(n);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/bitty_fetch_unit.md
# bitty_fetch_unit

Instruction sequencer that drives the Bitty core's instruction interface (`instraction`, `run`, `done`) from a small on-chip program memory. It is the initiator of the run/done handshake: it holds a program counter, fetches one 16-bit word, issues it with a `run` pulse, waits for the core's `done`, then advances. It also includes a program-load port and a completion watchdog. It sits between the test harness/host and `bitty_core`.

## Interface
- `DEPTH`, 256, program memory words (power of two)
- `ADDR_W`, 8, log2(DEPTH)
- `TIMEOUT`, 1024, max cycles to wait for `done` before flagging error
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: asynchronous, active-low
- `load_en` in 1: write `load_data` to memory at `load_addr` (honoured only in IDLE)
- `load_addr` in ADDR_W: program memory write address
- `load_data` in 16: program word
- `prog_len` in ADDR_W+1: number of instructions to execute, sampled on `start`
- `start` in 1: begin execution from address 0 (honoured only in IDLE)
- `done` in 1: from core, instruction complete
- `instraction` out 16: instruction word to core
- `run` out 1: one-cycle issue pulse to core
- `pc` out ADDR_W: address of current instruction
- `busy` out 1: high in any state other than IDLE
- `halted` out 1: sticky; last instruction completed
- `error` out 1: sticky; watchdog expired

## Operation
- FSM states: IDLE, FETCH, ISSUE, WAIT.
- IDLE: `busy`=0. `load_en`=1 writes memory. `start`=1 latches `len` = min(`prog_len`, DEPTH), sets `pc`=0, and clears `halted` and `error`.
  - If `len`=0: set `halted`=1 and remain in IDLE.
  - Otherwise go to FETCH.
- FETCH: memory read at `pc` (synchronous read). Go to ISSUE.
- ISSUE: register read data into `instraction` and assert `run`=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- WAIT: `instraction` is held stable. The watchdog increments each cycle.
  - On `done`=1: if `pc`=`len`-1, set `halted`=1 and go to IDLE; else `pc`<=`pc`+1 and go to FETCH.
  - If the counter reaches TIMEOUT-1 without `done`: set `error`=1 and go to IDLE, with `pc` frozen at the faulting address.
- `done` outside WAIT (including the ISSUE cycle) is ignored.
- `load_en` outside IDLE is ignored, so memory is unchanged during execution.
- `start` outside IDLE is ignored.
- `load_en` and `start` in the same IDLE cycle: the write happens and execution starts. The written word is visible to FETCH because FETCH is at least one cycle later.
- `pc` never wraps. The last legal value is DEPTH-1, enforced by clamping `len`.

## Timing
- Reset (async assert, synchronous deassert assumed by the system): state=IDLE, `pc`=0, `instraction`=16'h0000, `run`=0, `busy`=0, `halted`=0, `error`=0, watchdog=0. Memory contents are not reset.
- `start` sampled high at edge k: FETCH during cycle k+1, `run`=1 during cycle k+2.
- Issue-to-issue latency: `done` sampled at edge m gives next `run` high in cycle m+2. Minimum per instruction is 3 cycles plus core latency.
- `halted` and `error` rise one cycle after the deciding `done` or timeout edge. They stay high until the next accepted `start` or reset.
- Reset mid-operation returns immediately to the reset values above. No `run` is issued after reset asserts.

## Structure
- Shared package `bitty_pkg`:
  - `INSTR_W`=16
  - `fetch_state_t` enum {IDLE, FETCH, ISSUE, WAIT}
  - default DEPTH/TIMEOUT constants
- Sub-module `bitty_imem`: single-port synchronous RAM, DEPTH×16, one write port and one registered read port. The read-port mux is shared between load and fetch addresses, and only one is active per state.
- The FSM, pc, len latch and watchdog live in `bitty_fetch_unit`.

## Test plan
- Load words 0x1111, 0x2222, 0x3333 at 0..2; `prog_len`=3; `start`; core model returns `done` 4 cycles after each `run` → exactly 3 `run` pulses with `instraction` 0x1111, 0x2222, 0x3333 in order, then `halted`=1, `busy`=0, `pc`=2.
- `prog_len`=0, `start` → `halted`=1 next cycle, no `run`, `busy` stays 0.
- Core model never asserts `done`, TIMEOUT=16 → `error`=1 and IDLE 16 cycles after WAIT entry, `pc`=0, only one `run` seen.
- During execution assert `load_en` to address 1 with 0xDEAD and pulse spurious `start` → memory still 0x2222 at 1, sequence unaffected.
- `done` asserted in the ISSUE cycle and again 2 cycles later → only the second advances `pc`.
- Reset asserted while in WAIT → outputs immediately at reset values; a subsequent `start` with `prog_len`=1 issues one `run` with the word at address 0 and then sets `halted`.
